// File: rtl/prog_seq.sv
// prog_seq: program sequencer with a writable jump LUT, conditional/relative jumps, a call/return stack, stall and a sticky halt state.
// Ports: Clk/Reset (sync, active-high); Stall freezes sequencing; Jen/Jcond/Zero/Par conditional jump;
// Jptr selects the LUT target for jumps and calls; Call/Ret drive the stack; Halt stops; LutWen/LutWaddr/LutWdat write the LUT;
// PC current address; Done halted; StkOvf/StkUnf sticky stack errors.
module prog_seq #(
  parameter int PC_W = 10,
  parameter int JLUT_DEPTH = 16,
  parameter int STACK_DEPTH = 4,
  parameter int REL_JUMP = 0,
  parameter int HALT_ON_END = 1,
  localparam int JP_W = $clog2(JLUT_DEPTH)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Jen,
  input  logic [1:0]      Jcond,
  input  logic            Zero,
  input  logic            Par,
  input  logic [JP_W-1:0] Jptr,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Halt,
  input  logic            LutWen,
  input  logic [JP_W-1:0] LutWaddr,
  input  logic [PC_W-1:0] LutWdat,
  output logic [PC_W-1:0] PC,
  output logic            Done,
  output logic            StkOvf,
  output logic            StkUnf
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] lut [JLUT_DEPTH];
  logic [PC_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0] sp, sp_n;
  logic [PC_W-1:0] pc_n, pc_inc, tgt;
  logic ovf_n, unf_n, push, taken;
  assign pc_inc = PC + 1'b1;
  assign tgt = REL_JUMP != 0 ? PC + lut[Jptr] : lut[Jptr];
  assign taken = Jen && (Jcond == 2'b00 ? 1'b1 : Jcond == 2'b01 ? Zero : Jcond == 2'b10 ? !Zero : Par);
  assign Done = state == HALTED;
  always_comb begin
    state_n = state;
    pc_n = PC;
    sp_n = sp;
    ovf_n = StkOvf;
    unf_n = StkUnf;
    push = 1'b0;
    if (state == RUN && !Stall) begin
      if (Halt) state_n = HALTED;
      else if (Ret) begin
        if (sp == '0) begin
          unf_n = 1'b1;
          state_n = HALTED;
        end else begin
          pc_n = stk[IX_W'(sp - 1'b1)];
          sp_n = sp - 1'b1;
        end
      end else if (Call) begin
        if (sp == SP_W'(STACK_DEPTH)) begin
          ovf_n = 1'b1;
          state_n = HALTED;
        end else begin
          push = 1'b1;
          pc_n = tgt;
          sp_n = sp + 1'b1;
        end
      end else if (taken) pc_n = tgt;
      else if (HALT_ON_END != 0 && &PC) state_n = HALTED;
      else pc_n = pc_inc;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      PC <= '0;
      sp <= '0;
      StkOvf <= 1'b0;
      StkUnf <= 1'b0;
      for (int i = 0; i < JLUT_DEPTH; i++) lut[i] <= '0;
    end else begin
      state <= state_n;
      PC <= pc_n;
      sp <= sp_n;
      StkOvf <= ovf_n;
      StkUnf <= unf_n;
      if (LutWen) lut[LutWaddr] <= LutWdat;
    end
  end
  always_ff @(posedge Clk) begin
    if (push && !Reset) stk[IX_W'(sp)] <= pc_inc;
  end
endmodule

// File: tb/tb_prog_seq.sv
// tb_prog_seq: directed checks of prog_seq in absolute/halt-on-end, relative-jump and wrap-at-end configurations.
module tb_prog_seq;
  logic Clk = 1'b0;
  logic Reset, Stall, Jen, Zero, Par, Call, Ret, Halt, LutWen;
  logic [1:0] Jcond;
  logic [3:0] Jptr, LutWaddr;
  logic [9:0] LutWdat;
  logic [9:0] pc0, pc1, pc2;
  logic done0, done1, done2, ovf0, ovf1, ovf2, unf0, unf1, unf2;
  int checks = 0;
  int errors = 0;
  always #5 Clk = ~Clk;
  prog_seq #(.REL_JUMP(0), .HALT_ON_END(1)) u0 (.Clk(Clk), .Reset(Reset), .Stall(Stall), .Jen(Jen), .Jcond(Jcond),
    .Zero(Zero), .Par(Par), .Jptr(Jptr), .Call(Call), .Ret(Ret), .Halt(Halt), .LutWen(LutWen), .LutWaddr(LutWaddr),
    .LutWdat(LutWdat), .PC(pc0), .Done(done0), .StkOvf(ovf0), .StkUnf(unf0));
  prog_seq #(.REL_JUMP(1), .HALT_ON_END(1)) u1 (.Clk(Clk), .Reset(Reset), .Stall(Stall), .Jen(Jen), .Jcond(Jcond),
    .Zero(Zero), .Par(Par), .Jptr(Jptr), .Call(Call), .Ret(Ret), .Halt(Halt), .LutWen(LutWen), .LutWaddr(LutWaddr),
    .LutWdat(LutWdat), .PC(pc1), .Done(done1), .StkOvf(ovf1), .StkUnf(unf1));
  prog_seq #(.REL_JUMP(0), .HALT_ON_END(0)) u2 (.Clk(Clk), .Reset(Reset), .Stall(Stall), .Jen(Jen), .Jcond(Jcond),
    .Zero(Zero), .Par(Par), .Jptr(Jptr), .Call(Call), .Ret(Ret), .Halt(Halt), .LutWen(LutWen), .LutWaddr(LutWaddr),
    .LutWdat(LutWdat), .PC(pc2), .Done(done2), .StkOvf(ovf2), .StkUnf(unf2));
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic idle;
    {Stall, Jen, Zero, Par, Call, Ret, Halt, LutWen} = '0;
    Jcond = 2'b00;
    Jptr = 4'd0;
    LutWaddr = 4'd0;
    LutWdat = 10'd0;
  endtask
  task automatic reset_dut;
    idle();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask
  task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
    LutWen = 1'b1;
    LutWaddr = a;
    LutWdat = d;
    step();
    LutWen = 1'b0;
  endtask
  task automatic run_to(input logic [9:0] t);
    int n = 0;
    while (pc0 !== t && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (pc0 !== t) begin errors++; $display("FAIL run_to pc=%0d exp=%0d", pc0, t); end
  endtask
  task automatic test_reset;
    reset_dut();
    checks++; if (pc0 !== 10'd0 || done0 !== 1'b0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin errors++; $display("FAIL reset_state pc=%0d done=%b ovf=%b unf=%b exp=0 0 0 0", pc0, done0, ovf0, unf0); end
    checks++; if ({pc1, pc2} !== 20'd0 || {done1, done2, ovf1, ovf2, unf1, unf2} !== 6'd0) begin errors++; $display("FAIL reset_others pc1=%0d pc2=%0d flags=%b exp=0", pc1, pc2, {done1, done2, ovf1, ovf2, unf1, unf2}); end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (pc0 !== 10'(i) || done0 !== 1'b0) begin errors++; $display("FAIL idle_count pc=%0d done=%b exp=%0d 0", pc0, done0, i); end
    end
    Reset = 1'b1;
    Jen = 1'b1;
    Call = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc0 !== 10'd0) begin errors++; $display("FAIL reset_held pc=%0d exp=0", pc0); end
    end
    Reset = 1'b0;
    idle();
  endtask
  task automatic test_cond_jump;
    reset_dut();
    lut_write(4'd3, 10'd40);
    run_to(10'd7);
    Jen = 1'b1; Jcond = 2'b01; Jptr = 4'd3; Zero = 1'b0;
    step();
    checks++; if (pc0 !== 10'd8) begin errors++; $display("FAIL jz_not_taken pc=%0d exp=8", pc0); end
    Zero = 1'b1; LutWen = 1'b1; LutWaddr = 4'd3; LutWdat = 10'd50;
    step();
    checks++; if (pc0 !== 10'd40) begin errors++; $display("FAIL jz_taken_old_lut pc=%0d exp=40", pc0); end
    LutWen = 1'b0;
    step();
    checks++; if (pc0 !== 10'd50) begin errors++; $display("FAIL jz_new_lut pc=%0d exp=50", pc0); end
    Jcond = 2'b10;
    step();
    checks++; if (pc0 !== 10'd51) begin errors++; $display("FAIL jnz_not_taken pc=%0d exp=51", pc0); end
    Zero = 1'b0;
    step();
    checks++; if (pc0 !== 10'd50) begin errors++; $display("FAIL jnz_taken pc=%0d exp=50", pc0); end
    idle();
  endtask
  task automatic test_rel_jump;
    reset_dut();
    lut_write(4'd2, 10'h3FC);
    run_to(10'd10);
    Jen = 1'b1; Jcond = 2'b00; Jptr = 4'd2;
    step();
    checks++; if (pc1 !== 10'd6) begin errors++; $display("FAIL rel_back pc=%0d exp=6", pc1); end
    Jcond = 2'b11; Par = 1'b0;
    step();
    checks++; if (pc1 !== 10'd7) begin errors++; $display("FAIL rel_par0 pc=%0d exp=7", pc1); end
    Par = 1'b1;
    step();
    checks++; if (pc1 !== 10'd3) begin errors++; $display("FAIL rel_par1 pc=%0d exp=3", pc1); end
    idle();
  endtask
  task automatic test_call_ret;
    reset_dut();
    lut_write(4'd1, 10'd100);
    lut_write(4'd4, 10'd200);
    lut_write(4'd5, 10'd300);
    lut_write(4'd6, 10'd400);
    lut_write(4'd7, 10'd500);
    run_to(10'd20);
    Call = 1'b1; Jptr = 4'd1;
    step();
    checks++; if (pc0 !== 10'd100) begin errors++; $display("FAIL call pc=%0d exp=100", pc0); end
    Call = 1'b0; Ret = 1'b1; Jen = 1'b1; Jptr = 4'd7;
    step();
    checks++; if (pc0 !== 10'd21) begin errors++; $display("FAIL ret pc=%0d exp=21", pc0); end
    Ret = 1'b0; Jen = 1'b0; Call = 1'b1;
    Jptr = 4'd4; step();
    checks++; if (pc0 !== 10'd200) begin errors++; $display("FAIL nest1 pc=%0d exp=200", pc0); end
    Jptr = 4'd5; step();
    checks++; if (pc0 !== 10'd300) begin errors++; $display("FAIL nest2 pc=%0d exp=300", pc0); end
    Jptr = 4'd6; step();
    checks++; if (pc0 !== 10'd400) begin errors++; $display("FAIL nest3 pc=%0d exp=400", pc0); end
    Jptr = 4'd7; step();
    checks++; if (pc0 !== 10'd500 || done0 !== 1'b0) begin errors++; $display("FAIL nest4 pc=%0d done=%b exp=500 0", pc0, done0); end
    Call = 1'b0; Ret = 1'b1;
    step();
    checks++; if (pc0 !== 10'd401) begin errors++; $display("FAIL ret_top pc=%0d exp=401", pc0); end
    Ret = 1'b0; Call = 1'b1; Jptr = 4'd7;
    step();
    checks++; if (pc0 !== 10'd500 || ovf0 !== 1'b0) begin errors++; $display("FAIL refill pc=%0d ovf=%b exp=500 0", pc0, ovf0); end
    Jptr = 4'd1;
    step();
    checks++; if (pc0 !== 10'd500 || ovf0 !== 1'b1 || done0 !== 1'b1) begin errors++; $display("FAIL overflow pc=%0d ovf=%b done=%b exp=500 1 1", pc0, ovf0, done0); end
    Call = 1'b0; Jen = 1'b1;
    step();
    checks++; if (pc0 !== 10'd500 || done0 !== 1'b1) begin errors++; $display("FAIL ovf_hold pc=%0d done=%b exp=500 1", pc0, done0); end
    idle();
  endtask
  task automatic test_underflow;
    reset_dut();
    lut_write(4'd1, 10'd100);
    Ret = 1'b1;
    step();
    checks++; if (unf0 !== 1'b1 || done0 !== 1'b1 || pc0 !== 10'd1) begin errors++; $display("FAIL underflow unf=%b done=%b pc=%0d exp=1 1 1", unf0, done0, pc0); end
    Ret = 1'b0; Jen = 1'b1; Jptr = 4'd1; Call = 1'b1;
    step(); step();
    checks++; if (pc0 !== 10'd1 || ovf0 !== 1'b0 || done0 !== 1'b1) begin errors++; $display("FAIL halted_ignore pc=%0d ovf=%b done=%b exp=1 0 1", pc0, ovf0, done0); end
    idle();
    Reset = 1'b1; LutWen = 1'b1; LutWaddr = 4'd1; LutWdat = 10'd100;
    step();
    Reset = 1'b0; LutWen = 1'b0;
    checks++; if (pc0 !== 10'd0 || done0 !== 1'b0 || unf0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL reset_clears pc=%0d done=%b unf=%b ovf=%b exp=0 0 0 0", pc0, done0, unf0, ovf0); end
    Jen = 1'b1; Jptr = 4'd1;
    step();
    checks++; if (pc0 !== 10'd0) begin errors++; $display("FAIL reset_clears_lut pc=%0d exp=0", pc0); end
    idle();
  endtask
  task automatic test_stall;
    reset_dut();
    run_to(10'd12);
    Stall = 1'b1; Jen = 1'b1; Jptr = 4'd9; LutWen = 1'b1; LutWaddr = 4'd9; LutWdat = 10'd77;
    for (int i = 0; i < 3; i++) begin
      step();
      LutWen = 1'b0;
      checks++; if (pc0 !== 10'd12) begin errors++; $display("FAIL stall pc=%0d exp=12", pc0); end
    end
    Stall = 1'b0;
    step();
    checks++; if (pc0 !== 10'd77) begin errors++; $display("FAIL stall_lut_write pc=%0d exp=77", pc0); end
    idle();
  endtask
  task automatic test_halt;
    reset_dut();
    run_to(10'd30);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL pre_halt done=%b exp=0", done0); end
    Halt = 1'b1; Jen = 1'b1; Call = 1'b1;
    step();
    checks++; if (done0 !== 1'b1 || pc0 !== 10'd30) begin errors++; $display("FAIL halt done=%b pc=%0d exp=1 30", done0, pc0); end
    Halt = 1'b0; Ret = 1'b1;
    step(); step(); step();
    checks++; if (done0 !== 1'b1 || pc0 !== 10'd30 || unf0 !== 1'b0) begin errors++; $display("FAIL halt_hold done=%b pc=%0d unf=%b exp=1 30 0", done0, pc0, unf0); end
    idle();
  endtask
  task automatic test_end;
    reset_dut();
    lut_write(4'd8, 10'd1020);
    Jen = 1'b1; Jptr = 4'd8;
    step();
    Jen = 1'b0;
    checks++; if (pc0 !== 10'd1020 || pc2 !== 10'd1020) begin errors++; $display("FAIL end_jump pc0=%0d pc2=%0d exp=1020", pc0, pc2); end
    step(); step(); step();
    checks++; if (pc0 !== 10'd1023 || done0 !== 1'b0) begin errors++; $display("FAIL end_max pc=%0d done=%b exp=1023 0", pc0, done0); end
    step();
    checks++; if (pc0 !== 10'd1023 || done0 !== 1'b1) begin errors++; $display("FAIL end_halt pc=%0d done=%b exp=1023 1", pc0, done0); end
    checks++; if (pc2 !== 10'd0 || done2 !== 1'b0) begin errors++; $display("FAIL end_wrap pc=%0d done=%b exp=0 0", pc2, done2); end
    step();
    checks++; if (pc0 !== 10'd1023 || pc2 !== 10'd1) begin errors++; $display("FAIL end_after pc0=%0d pc2=%0d exp=1023 1", pc0, pc2); end
    idle();
  endtask
  initial begin
    idle();
    Reset = 1'b1;
    test_reset();
    test_cond_jump();
    test_rel_jump();
    test_call_ret();
    test_underflow();
    test_stall();
    test_halt();
    test_end();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
